// File: rtl/ltssm_pkg.sv
// Shared symbol encodings, ordered-set IDs and types for the LTSSM receive path.
// Used by os_receiver and (with OS_RX_CONSEC_CNT_EN) os_ts_field_cmp.
package ltssm_pkg;

    typedef enum logic [7:0] {
        K_COM = 8'h1C,
        K_SKP = 8'hDC,
        K_FTS = 8'hFC,
        K_IDL = 8'hF7,
        K_PAD = 8'hBC
    } k_symbols_e;

    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef enum logic [2:0] {
        OS_NONE,
        OS_TS1,
        OS_TS2,
        OS_SKP,
        OS_FTS,
        OS_EIOS
    } os_type_e;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_TYPE,
        ST_TS_BODY,
        ST_SHORT_OS
    } os_rx_state_e;

    typedef struct packed {
        logic [7:0] link;
        logic [7:0] lane;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] ctrl;
        logic       link_pad;
        logic       lane_pad;
    } ts_fields_t;

endpackage

// File: rtl/os_ts_field_cmp.sv
// Remembers symbols 1..5 and type of the last completed TS and flags a repeat.
// Only built when OS_RX_CONSEC_CNT_EN is defined.
`ifdef OS_RX_CONSEC_CNT_EN
module os_ts_field_cmp
    import ltssm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  ts_fields_t i_fields,
    input  os_type_e   i_type,
    output logic       o_match
);

    logic       r_valid;
    ts_fields_t r_prev;
    os_type_e   r_prev_type;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // NOTE: payload registers carry no reset; r_valid gates every use of them.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_prev      <= i_fields;
            r_prev_type <= i_type;
        end
    end

    assign o_match = r_valid && (r_prev == i_fields) && (r_prev_type == i_type);

endmodule
`endif

// File: rtl/os_receiver.sv
// Ordered-set receiver: frames TS1/TS2/SKP/FTS/EIOS from a decoded symbol stream.
// Define OS_RX_CONSEC_CNT_EN to build the consecutive-identical-TS counter.
module os_receiver
    import ltssm_pkg::*;
#(
    parameter int unsigned CONSEC_MAX = 15
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_is_k,
    input  logic       rx_lock,
    output logic       ts1_det,
    output logic       ts2_det,
    output logic [7:0] ts_link,
    output logic [7:0] ts_lane,
    output logic [7:0] ts_nfts,
    output logic [7:0] ts_rate,
    output logic [7:0] ts_ctrl,
    output logic       ts_link_pad,
    output logic       ts_lane_pad,
    output logic       skp_det,
    output logic       fts_det,
    output logic       eios_det,
    output logic       os_err,
    output logic [3:0] ts_consec
);

    os_rx_state_e r_state, w_state_nxt;
    logic [3:0]   r_idx, w_idx_nxt;
    logic [7:0]   r_id, w_id_nxt;
    logic [7:0]   r_short, w_short_nxt;
    ts_fields_t   r_sh, w_sh_nxt;
    ts_fields_t   r_fields;
    os_type_e     r_done, w_done_nxt;
    logic         r_err, w_err;
    logic         w_is_com, w_is_pad, w_sym_ok, w_ts_done;

    assign w_is_com  = rx_is_k && (rx_data == K_COM);
    assign w_is_pad  = rx_is_k && (rx_data == K_PAD);
    assign w_ts_done = (w_done_nxt == OS_TS1) || (w_done_nxt == OS_TS2);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_id_nxt    = r_id;
        w_short_nxt = r_short;
        w_sh_nxt    = r_sh;
        w_done_nxt  = OS_NONE;
        w_err       = 1'b0;
        w_sym_ok    = 1'b0;
        if (!rx_lock) begin
            w_state_nxt = ST_HUNT;
            w_idx_nxt   = '0;
        end else if (rx_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_is_com) begin
                        w_state_nxt = ST_TYPE;
                        w_idx_nxt   = 4'd1;
                    end
                end
                ST_TYPE: begin
                    if (rx_is_k && (rx_data == K_SKP || rx_data == K_FTS || rx_data == K_IDL)) begin
                        w_state_nxt = ST_SHORT_OS;
                        w_idx_nxt   = 4'd2;
                        w_short_nxt = rx_data;
                    end else if (!rx_is_k || w_is_pad) begin
                        w_state_nxt       = ST_TS_BODY;
                        w_idx_nxt         = 4'd2;
                        w_sh_nxt.link     = rx_data;
                        w_sh_nxt.link_pad = w_is_pad;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_TS_BODY: begin
                    w_sym_ok = !rx_is_k;
                    case (r_idx)
                        4'd2: begin
                            w_sym_ok          = !rx_is_k || w_is_pad;
                            w_sh_nxt.lane     = rx_data;
                            w_sh_nxt.lane_pad = w_is_pad;
                        end
                        4'd3: w_sh_nxt.nfts = rx_data;
                        4'd4: w_sh_nxt.rate = rx_data;
                        4'd5: w_sh_nxt.ctrl = rx_data;
                        4'd6: begin
                            w_sym_ok = !rx_is_k && (rx_data == TS1_ID || rx_data == TS2_ID);
                            w_id_nxt = rx_data;
                        end
                        default: w_sym_ok = !rx_is_k && (rx_data == r_id);
                    endcase
                    if (!w_sym_ok) begin
                        w_err = 1'b1;
                    end else if (r_idx == 4'd15) begin
                        w_done_nxt  = (r_id == TS2_ID) ? OS_TS2 : OS_TS1;
                        w_state_nxt = ST_HUNT;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
                ST_SHORT_OS: begin
                    if (!(rx_is_k && rx_data == r_short)) begin
                        w_err = 1'b1;
                    end else if (r_idx == 4'd3) begin
                        w_state_nxt = ST_HUNT;
                        w_idx_nxt   = '0;
                        case (r_short)
                            K_SKP:   w_done_nxt = OS_SKP;
                            K_FTS:   w_done_nxt = OS_FTS;
                            default: w_done_nxt = OS_EIOS;
                        endcase
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
            // A COM that breaks a set is itself the start of the next one.
            if (w_err) begin
                w_state_nxt = w_is_com ? ST_TYPE : ST_HUNT;
                w_idx_nxt   = w_is_com ? 4'd1 : 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_HUNT;
            r_idx    <= '0;
            r_done   <= OS_NONE;
            r_err    <= 1'b0;
            r_fields <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err;
            if (w_ts_done) begin
                r_fields <= r_sh;
            end
        end
    end

    // Capture registers for the set in flight; only committed on completion.
    always_ff @(posedge clk) begin
        r_id    <= w_id_nxt;
        r_short <= w_short_nxt;
        r_sh    <= w_sh_nxt;
    end

`ifdef OS_RX_CONSEC_CNT_EN
    logic       w_match;
    logic [3:0] r_consec;

    os_ts_field_cmp u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_ts_done),
        .i_fields (r_sh),
        .i_type   (w_done_nxt),
        .o_match  (w_match)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !rx_lock || w_err) begin
            r_consec <= '0;
        end else if (w_ts_done) begin
            if (!w_match) begin
                r_consec <= 4'd1;
            end else if (r_consec < 4'(CONSEC_MAX)) begin
                r_consec <= r_consec + 4'd1;
            end
        end
    end

    assign ts_consec = r_consec;
`else
    assign ts_consec = 4'd0;
`endif

    assign ts1_det     = (r_done == OS_TS1);
    assign ts2_det     = (r_done == OS_TS2);
    assign skp_det     = (r_done == OS_SKP);
    assign fts_det     = (r_done == OS_FTS);
    assign eios_det    = (r_done == OS_EIOS);
    assign os_err      = r_err;
    assign ts_link     = r_fields.link;
    assign ts_lane     = r_fields.lane;
    assign ts_nfts     = r_fields.nfts;
    assign ts_rate     = r_fields.rate;
    assign ts_ctrl     = r_fields.ctrl;
    assign ts_link_pad = r_fields.link_pad;
    assign ts_lane_pad = r_fields.lane_pad;

endmodule

// File: tb/tb_os_receiver.sv
// Directed bench for os_receiver: short-set table plus multi-cycle TS sequences.
// Counter expectations follow whether OS_RX_CONSEC_CNT_EN is defined.
module tb_os_receiver;

    localparam logic [7:0] COM = 8'h1C, SKP = 8'hDC, FTS = 8'hFC, IDL = 8'hF7, PAD = 8'hBC;
    localparam logic [7:0] ID1 = 8'h4A, ID2 = 8'h45;
    // Pulse vector order: {ts1, ts2, skp, fts, eios, err}
    localparam logic [5:0] P_NONE = 6'b000000, P_TS1 = 6'b100000, P_TS2 = 6'b010000;
    localparam logic [5:0] P_SKP = 6'b001000, P_FTS = 6'b000100, P_EIOS = 6'b000010, P_ERR = 6'b000001;
`ifdef OS_RX_CONSEC_CNT_EN
    localparam bit CONSEC_EN = 1'b1;
`else
    localparam bit CONSEC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, rx_valid, rx_is_k, rx_lock;
    logic [7:0] rx_data;
    logic       ts1_det, ts2_det, ts_link_pad, ts_lane_pad;
    logic       skp_det, fts_det, eios_det, os_err;
    logic [7:0] ts_link, ts_lane, ts_nfts, ts_rate, ts_ctrl;
    logic [3:0] ts_consec;

    os_receiver #(.CONSEC_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_is_k(rx_is_k), .rx_lock(rx_lock),
        .ts1_det(ts1_det), .ts2_det(ts2_det),
        .ts_link(ts_link), .ts_lane(ts_lane), .ts_nfts(ts_nfts),
        .ts_rate(ts_rate), .ts_ctrl(ts_ctrl),
        .ts_link_pad(ts_link_pad), .ts_lane_pad(ts_lane_pad),
        .skp_det(skp_det), .fts_det(fts_det), .eios_det(eios_det),
        .os_err(os_err), .ts_consec(ts_consec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       lock;
        logic       k;
        logic [7:0] d;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] ts_buf[16];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic vec_t mk(input logic v, input logic lock, input logic k,
                                input logic [7:0] d, input logic [5:0] exp);
        vec_t r;
        r.v = v; r.lock = lock; r.k = k; r.d = d; r.exp = exp;
        return r;
    endfunction

    function automatic logic [5:0] pulses();
        return {ts1_det, ts2_det, skp_det, fts_det, eios_det, os_err};
    endfunction

    function automatic logic [3:0] exp_consec(input int n);
        return CONSEC_EN ? 4'(n) : 4'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic lock, input logic k, input logic [7:0] d,
                        input logic [5:0] exp, input string name);
        @(negedge clk);
        rx_valid = v; rx_lock = lock; rx_is_k = k; rx_data = d;
        @(posedge clk);
        #1;
        check(name, 32'(pulses()), 32'(exp));
    endtask

    task automatic build_ts(input logic [7:0] link, input logic [7:0] lane, input logic [7:0] nfts,
                            input logic [7:0] rate, input logic [7:0] ctrl, input logic [7:0] id,
                            input bit lpad, input bit npad);
        ts_buf[0] = {1'b1, COM};
        ts_buf[1] = lpad ? {1'b1, PAD} : {1'b0, link};
        ts_buf[2] = npad ? {1'b1, PAD} : {1'b0, lane};
        ts_buf[3] = {1'b0, nfts};
        ts_buf[4] = {1'b0, rate};
        ts_buf[5] = {1'b0, ctrl};
        for (int i = 6; i < 16; i++) ts_buf[i] = {1'b0, id};
    endtask

    task automatic send_buf(input int lo, input int hi, input logic [5:0] exp_last,
                            input bit gaps, input string name);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) send(1'b0, 1'b1, 1'b0, 8'h00, P_NONE, {name, "_gap"});
            send(1'b1, 1'b1, ts_buf[i][8], ts_buf[i][7:0], (i == hi) ? exp_last : P_NONE,
                 $sformatf("%s[%0d]", name, i));
        end
    endtask

    task automatic check_fields(input string name, input logic [7:0] link, input logic [7:0] lane,
                                input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctrl);
        check({name, "_link"}, 32'(ts_link), 32'(link));
        check({name, "_lane"}, 32'(ts_lane), 32'(lane));
        check({name, "_nfts"}, 32'(ts_nfts), 32'(nfts));
        check({name, "_rate"}, 32'(ts_rate), 32'(rate));
        check({name, "_ctrl"}, 32'(ts_ctrl), 32'(ctrl));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_pulses"}, 32'(pulses()), 32'(P_NONE));
        check_fields(name, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check({name, "_pads"}, 32'({ts_link_pad, ts_lane_pad}), 32'(2'b00));
        check({name, "_consec"}, 32'(ts_consec), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_lock = 1'b0; rx_is_k = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Short ordered sets, hunting and framing errors
        tbl.push_back(mk(1, 1, 0, 8'h00, P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_SKP));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, FTS,   P_NONE));
        tbl.push_back(mk(1, 1, 1, FTS,   P_NONE));
        tbl.push_back(mk(1, 1, 1, FTS,   P_FTS));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, IDL,   P_NONE));
        tbl.push_back(mk(1, 1, 1, IDL,   P_NONE));
        tbl.push_back(mk(1, 1, 1, IDL,   P_EIOS));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, COM,   P_ERR));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_SKP));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, FTS,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_ERR));
        tbl.push_back(mk(1, 1, 1, FTS,   P_NONE));
        tbl.push_back(mk(1, 1, 1, FTS,   P_NONE));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, IDL,   P_NONE));
        tbl.push_back(mk(0, 1, 1, IDL,   P_NONE));
        tbl.push_back(mk(1, 1, 1, IDL,   P_NONE));
        tbl.push_back(mk(1, 1, 1, IDL,   P_EIOS));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, 8'h3C, P_ERR));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 0, 8'h00, P_ERR));
        tbl.push_back(mk(1, 1, 1, COM,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 0, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        tbl.push_back(mk(1, 1, 1, SKP,   P_NONE));
        for (int i = 0; i < tbl.size(); i++)
            send(tbl[i].v, tbl[i].lock, tbl[i].k, tbl[i].d, tbl[i].exp, $sformatf("tbl%0d", i));

        // Basic TS1
        build_ts(8'h01, 8'h00, 8'h1F, 8'h02, 8'h00, ID1, 0, 0);
        send_buf(0, 15, P_TS1, 0, "A");
        check_fields("A", 8'h01, 8'h00, 8'h1F, 8'h02, 8'h00);
        check("A_consec", 32'(ts_consec), 32'(exp_consec(1)));

        // Eight identical TS2 with a SKP set after the fourth
        build_ts(8'h01, 8'h00, 8'h1F, 8'h02, 8'h00, ID2, 0, 0);
        for (int n = 1; n <= 8; n++) begin
            send_buf(0, 15, P_TS2, 0, $sformatf("B%0d", n));
            check($sformatf("B%0d_consec", n), 32'(ts_consec), 32'(exp_consec(n)));
            if (n == 4) begin
                send(1, 1, 1, COM, P_NONE, "B_skp0");
                send(1, 1, 1, SKP, P_NONE, "B_skp1");
                send(1, 1, 1, SKP, P_NONE, "B_skp2");
                send(1, 1, 1, SKP, P_SKP,  "B_skp3");
                check("B_skp_consec", 32'(ts_consec), 32'(exp_consec(4)));
            end
        end

        // TS1 whose ID symbol 9 is a TS2 ID; trailing symbols are ignored in HUNT
        build_ts(8'h07, 8'h03, 8'h20, 8'h04, 8'h01, ID1, 0, 0);
        ts_buf[9] = {1'b0, ID2};
        send_buf(0, 9, P_ERR, 0, "C");
        send_buf(10, 15, P_NONE, 0, "C_tail");
        check_fields("C", 8'h01, 8'h00, 8'h1F, 8'h02, 8'h00);
        check("C_consec", 32'(ts_consec), 32'd0);

        // TS1 cut by COM at index 10, that COM opens a SKP set
        build_ts(8'h05, 8'h02, 8'h10, 8'h02, 8'h00, ID1, 0, 0);
        send_buf(0, 9, P_NONE, 0, "D");
        send(1, 1, 1, COM, P_ERR,  "D_com");
        send(1, 1, 1, SKP, P_NONE, "D_skp1");
        send(1, 1, 1, SKP, P_NONE, "D_skp2");
        send(1, 1, 1, SKP, P_SKP,  "D_skp3");
        check_fields("D", 8'h01, 8'h00, 8'h1F, 8'h02, 8'h00);

        // Gapped TS1, lock lost at index 7, then a complete gapped TS1
        build_ts(8'h0A, 8'h01, 8'h10, 8'h02, 8'h08, ID1, 0, 0);
        send_buf(0, 6, P_NONE, 1, "E_part");
        send(1, 0, 0, ID1, P_NONE, "E_lock");
        check("E_lock_consec", 32'(ts_consec), 32'd0);
        send_buf(0, 15, P_TS1, 1, "E");
        check_fields("E", 8'h0A, 8'h01, 8'h10, 8'h02, 8'h08);
        check("E_consec", 32'(ts_consec), 32'(exp_consec(1)));

        // Reset at index 12 of an identical TS1
        send_buf(0, 11, P_NONE, 0, "F_part");
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b1; rx_lock = 1'b1; rx_is_k = 1'b0; rx_data = ID1;
        @(posedge clk);
        #1;
        check_reset_state("F_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send_buf(0, 15, P_TS1, 0, "F");
        check_fields("F", 8'h0A, 8'h01, 8'h10, 8'h02, 8'h08);
        check("F_consec", 32'(ts_consec), 32'(exp_consec(1)));

        // Repeat until the counter saturates
        for (int n = 2; n <= 17; n++) begin
            send_buf(0, 15, P_TS1, 0, $sformatf("G%0d", n));
            check($sformatf("G%0d_consec", n), 32'(ts_consec), 32'(exp_consec((n > 15) ? 15 : n)));
        end

        // TS2 with PAD link and lane
        build_ts(8'h00, 8'h00, 8'h33, 8'h06, 8'h02, ID2, 1, 1);
        send_buf(0, 15, P_TS2, 0, "H");
        check("H_pads", 32'({ts_link_pad, ts_lane_pad}), 32'(2'b11));
        check("H_nfts", 32'(ts_nfts), 32'h33);
        check("H_consec", 32'(ts_consec), 32'(exp_consec(1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/os_receiver.md
OS_RECEIVER -- requirements
Module: os_receiver

Interface
REQ-001 SHALL have parameter CONSEC_MAX, default 15, meaning the saturation value of the consecutive-TS counter (1..15).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: rx_valid  in  1  symbol qualifier; rx_data  in  8  decoded symbol; rx_is_k  in  1  symbol is K-code; rx_lock  in  1  symbol lock from decoder.
REQ-005 SHALL have ports: ts1_det  out  1  pulse, valid TS1 received; ts2_det  out  1  pulse, valid TS2 received.
REQ-006 SHALL have ports: ts_link  out  8, ts_lane  out  8, ts_nfts  out  8, ts_rate  out  8, ts_ctrl  out  8: fields of the last valid TS; ts_link_pad  out  1 and ts_lane_pad  out  1: field was PAD.
REQ-007 SHALL have ports: skp_det, fts_det, eios_det  out  1 each  pulses; os_err  out  1  pulse, malformed ordered set; ts_consec  out  4  count of consecutive identical TS.

Function
REQ-008 SHALL accept a symbol only in cycles with rx_valid=1 and rx_lock=1; rx_valid=0 holds all state.
REQ-009 SHALL implement FSM HUNT -> TYPE -> {TS_BODY | SHORT_OS} -> HUNT, with a 4-bit symbol index.
REQ-010 HUNT: COM (K, 8'h1C) -> TYPE; any other symbol ignored, no error.
REQ-011 TYPE: K SKP (8'hDC), FTS (8'hFC) or IDL (8'hF7) -> SHORT_OS expecting 2 more identical K symbols; D symbol or PAD (K, 8'hBC) -> TS_BODY as link field; anything else -> os_err.
REQ-012 TS_BODY: index 2 lane (D or PAD), 3 N_FTS, 4 rate, 5 training control (all D); indexes 6..15 SHALL all be D 8'h4A (TS1) or all D 8'h45 (TS2), type fixed by index 6.
REQ-013 Any K symbol at index 3..15, or an ID symbol differing from index 6, SHALL pulse os_err for 1 cycle.
REQ-014 On error, if the offending symbol is COM, FSM SHALL go to TYPE (new set start); otherwise to HUNT.
REQ-015 Completion pulses (ts1/ts2/skp/fts/eios_det) SHALL assert exactly 1 cycle, in the cycle after the last symbol is accepted.
REQ-016 ts_* fields and *_pad SHALL update in the same cycle as ts1_det/ts2_det and hold otherwise; partially received sets SHALL NOT change them.
REQ-017 ts_consec SHALL increment (saturating at CONSEC_MAX) when a completed TS has the same type and identical symbols 1..5 as the previous TS, SHALL load 1 otherwise, and SHALL clear to 0 on os_err or rx_lock deassertion; SKP sets between TS SHALL NOT affect it.
REQ-018 rx_lock=0 SHALL force HUNT next cycle with no os_err and no detection pulse.
REQ-019 At most one of the detection pulses and os_err SHALL be high in any cycle.

Reset
REQ-020 rst_n=0 at a rising edge SHALL set FSM to HUNT, index 0, all pulses 0, ts_* fields 8'h00, *_pad 0, ts_consec 0; reset mid-set SHALL discard the partial set.

Configuration
REQ-021 Macro OS_RX_CONSEC_CNT_EN defined: consecutive counter per REQ-017 present.
REQ-022 Macro undefined: no counter or previous-TS storage; ts_consec SHALL be constant 4'd0; all other behaviour unchanged.

Structure
REQ-023 Symbol encodings SHALL come from k_symbols_e in ltssm_pkg; TS1/TS2 ID constants (8'h4A, 8'h45), the ordered-set type enum and the FSM state enum SHALL be added to ltssm_pkg.
REQ-024 A single sub-module os_ts_field_cmp (registers previous TS symbols 1..5, outputs match) is natural and SHALL exist only under OS_RX_CONSEC_CNT_EN.

Verification
REQ-025 COM,8'h01,8'h00,8'h1F,8'h02,8'h00,10x8'h4A contiguous -> ts1_det pulse 1 cycle after last symbol; ts_link=01, ts_lane=00, ts_nfts=1F, ts_rate=02, ts_consec=1.
REQ-026 8 identical TS2 (ID 8'h45) back-to-back with one SKP set between sets 4 and 5 -> 8 ts2_det pulses, 1 skp_det, ts_consec ends at 8.
REQ-027 TS1 with ID symbol 9 = 8'h45 -> os_err at that symbol, no ts1_det, fields unchanged, ts_consec=0.
REQ-028 TS1 truncated by COM at index 10 followed by full SKP set -> os_err then skp_det, no ts1_det.
REQ-029 TS1 with random rx_valid gaps; rx_lock dropped at index 7 then full TS1 -> only the second set detected, no os_err.
REQ-030 Reset asserted at index 12 of a TS1 -> all outputs at reset values next cycle; subsequent TS1 detected normally with ts_consec=1.
